// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcomes, BHT counter encoding and the saturating train step.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_outcome_t;

    typedef logic [1:0] bht_counter_t;

    localparam bht_counter_t BHT_WEAK_NT = 2'b01;
    localparam bht_counter_t BHT_MAX     = 2'b11;

    // One training step of a 2-bit saturating counter.
    function automatic bht_counter_t bht_train(input bht_counter_t ctr, input branch_outcome_t outcome);
        bht_counter_t nxt;
        nxt = ctr;
        if (outcome == TAKEN) begin
            if (ctr != BHT_MAX) nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_decoded_ifc.sv
// Decode-stage branch handshake: decode supplies the branch, the predictor answers combinationally.
interface branch_decoded_ifc;
    import mips_core_pkg::*;

    logic                  valid;
    logic                  is_jump;
    logic [ADDR_WIDTH-1:0] target;
    branch_outcome_t       prediction;
    logic [ADDR_WIDTH-1:0] recovery_target;

    modport decode (
        output valid, is_jump, target,
        input  prediction, recovery_target
    );

    modport hazard (
        input  valid, is_jump, target,
        output prediction, recovery_target
    );
endinterface

// File: rtl/branch_result_ifc.sv
// EX-stage branch resolution: the prediction made in decode alongside the actual outcome.
interface branch_result_ifc;
    import mips_core_pkg::*;

    logic                  valid;
    branch_outcome_t       prediction;
    branch_outcome_t       outcome;
    logic [ADDR_WIDTH-1:0] recovery_target;

    modport out (
        output valid, prediction, outcome, recovery_target
    );

    modport in (
        input valid, prediction, outcome, recovery_target
    );
endinterface

// File: rtl/branch_index_queue.sv
// In-order FIFO of BHT indices for branches between decode and EX; registered, head is combinational.
// A push into a full queue is accepted only alongside a pop; flush empties it and discards a same-cycle push.
module branch_index_queue #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// 2-bit saturating-counter branch predictor: zero-latency prediction in decode, training on EX resolution.
// Never stalls; a conditional branch arriving while the index queue is full is dropped and flagged sticky.
module branch_predictor_unit
    import mips_core_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_dec_advance,
    input  logic                  i_ex_advance,
    branch_decoded_ifc.hazard     branch_decoded,
    branch_result_ifc.in          branch_result,
    output logic                  o_mispredict,
    output logic [31:0]           o_branch_count,
    output logic [31:0]           o_mispredict_count,
    output logic                  o_overflow
);

    localparam int BHT_ENTRIES = 2 ** INDEX_WIDTH;

    bht_counter_t             bht_q [BHT_ENTRIES];
    bht_counter_t             bht_d;
    logic [INDEX_WIDTH-1:0]   pred_idx;
    bht_counter_t             pred_ctr;
    logic [ADDR_WIDTH-1:0]    fallthrough_pc;

    logic                     push_req;
    logic                     pop_req;
    logic                     train_en;
    logic [INDEX_WIDTH-1:0]   q_head;
    logic                     q_full;
    logic                     q_empty;

    logic [31:0]              branch_count_q, branch_count_d;
    logic [31:0]              mispredict_count_q, mispredict_count_d;
    logic                     overflow_q, overflow_d;
    logic                     unused_recovery;

    // Recovery target on the result side is consumed by the fetch redirect, not here.
    assign unused_recovery = ^branch_result.recovery_target;

    assign pred_idx       = i_pc[INDEX_WIDTH+1:2];
    assign pred_ctr       = bht_q[pred_idx];
    assign fallthrough_pc = i_pc + ADDR_WIDTH'(8);

    always_comb begin
        branch_decoded.prediction      = NOT_TAKEN;
        branch_decoded.recovery_target = fallthrough_pc;
        if (branch_decoded.valid) begin
            if (branch_decoded.is_jump) begin
                branch_decoded.prediction      = TAKEN;
                branch_decoded.recovery_target = branch_decoded.target;
            end else if (pred_ctr[1]) begin
                branch_decoded.prediction      = TAKEN;
                branch_decoded.recovery_target = fallthrough_pc;
            end else begin
                branch_decoded.prediction      = NOT_TAKEN;
                branch_decoded.recovery_target = branch_decoded.target;
            end
        end
    end

    assign push_req     = branch_decoded.valid & ~branch_decoded.is_jump & i_dec_advance;
    assign pop_req      = branch_result.valid & i_ex_advance;
    assign o_mispredict = pop_req & (branch_result.prediction != branch_result.outcome);

    // A mispredict flushes the wrong-path entries behind the head and any same-cycle push.
    branch_index_queue #(
        .WIDTH (INDEX_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .flush_i (o_mispredict),
        .data_i  (pred_idx),
        .head_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign train_en = pop_req & ~q_empty;
    assign bht_d    = bht_train(bht_q[q_head], branch_result.outcome);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_WEAK_NT;
        end else if (train_en) begin
            bht_q[q_head] <= bht_d;
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        overflow_d         = overflow_q;
        if (pop_req && branch_count_q != 32'hFFFF_FFFF)
            branch_count_d = branch_count_q + 32'd1;
        if (o_mispredict && mispredict_count_q != 32'hFFFF_FFFF)
            mispredict_count_d = mispredict_count_q + 32'd1;
        if (push_req && q_full && !pop_req)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            overflow_q         <= 1'b0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            overflow_q         <= overflow_d;
        end
    end

    assign o_branch_count     = branch_count_q;
    assign o_mispredict_count = mispredict_count_q;
    assign o_overflow         = overflow_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench for branch_predictor_unit with a cycle-tagged expectation queue and a negedge monitor.
module tb_branch_predictor_unit;
    import mips_core_pkg::*;

    localparam int S_PRED = 0;
    localparam int S_RTGT = 1;
    localparam int S_MISP = 2;
    localparam int S_BCNT = 3;
    localparam int S_MCNT = 4;
    localparam int S_OVF  = 5;
    localparam int S_OCC  = 6;
    localparam int S_BHT  = 7;

    typedef struct {
        int          cyc;
        int          sel;
        int          idx;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] i_pc;
    logic        i_dec_advance;
    logic        i_ex_advance;
    logic        o_mispredict;
    logic [31:0] o_branch_count;
    logic [31:0] o_mispredict_count;
    logic        o_overflow;

    branch_decoded_ifc bd ();
    branch_result_ifc  br ();

    exp_t sb [$];
    int   cyc;
    int   n_checks;
    int   n_errors;

    branch_predictor_unit #(
        .INDEX_WIDTH (6),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_pc               (i_pc),
        .i_dec_advance      (i_dec_advance),
        .i_ex_advance       (i_ex_advance),
        .branch_decoded     (bd),
        .branch_result      (br),
        .o_mispredict       (o_mispredict),
        .o_branch_count     (o_branch_count),
        .o_mispredict_count (o_mispredict_count),
        .o_overflow         (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int sel);
        case (sel)
            S_PRED:  return "prediction";
            S_RTGT:  return "recovery_target";
            S_MISP:  return "o_mispredict";
            S_BCNT:  return "o_branch_count";
            S_MCNT:  return "o_mispredict_count";
            S_OVF:   return "o_overflow";
            S_OCC:   return "occupancy";
            default: return "bht";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int sel, input int idx);
        logic [5:0] bi;
        logic [2:0] occ;
        bi  = idx[5:0];
        occ = dut.u_queue.wptr_q - dut.u_queue.rptr_q;
        case (sel)
            S_PRED:  return 32'(bd.prediction);
            S_RTGT:  return bd.recovery_target;
            S_MISP:  return 32'(o_mispredict);
            S_BCNT:  return o_branch_count;
            S_MCNT:  return o_mispredict_count;
            S_OVF:   return 32'(o_overflow);
            S_OCC:   return 32'(occ);
            default: return 32'(dut.bht_q[bi]);
        endcase
    endfunction

    task automatic expect_val(input int sel, input int idx, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc;
        e.sel = sel;
        e.idx = idx;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] pc, input logic dv, input logic jmp, input logic [31:0] tgt,
                         input logic dadv, input logic rv, input logic rpred, input logic rout,
                         input logic exadv);
        @(posedge clk);
        #1;
        i_pc           = pc;
        bd.valid       = dv;
        bd.is_jump     = jmp;
        bd.target      = tgt;
        i_dec_advance  = dadv;
        br.valid       = rv;
        br.prediction  = branch_outcome_t'(rpred);
        br.outcome     = branch_outcome_t'(rout);
        br.recovery_target = 32'h0;
        i_ex_advance   = exadv;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic dec(input logic [31:0] pc, input logic [31:0] tgt);
        drive(pc, 1'b1, 1'b0, tgt, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic res(input logic rpred, input logic rout);
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, rpred, rout, 1'b1);
    endtask

    // Monitor: compares every expectation tagged with the current cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                act = actual(e.sel, e.idx);
                if (e.cyc != cyc) begin
                    n_errors++;
                    $display("FAIL %s idx=%0d stale expectation from cyc=%0d at cyc=%0d required=0x%0h",
                             sel_name(e.sel), e.idx, e.cyc, cyc, e.val);
                end else if (act !== e.val) begin
                    n_errors++;
                    $display("FAIL %s idx=%0d cyc=%0d actual=0x%0h required=0x%0h",
                             sel_name(e.sel), e.idx, cyc, act, e.val);
                end
            end
        end
    end

    localparam logic [3:0] NT_PRED  = 4'b0011;
    localparam logic [3:0] NT_MISP  = 4'b0011;
    localparam logic [7:0] NT_AFTER = {2'd0, 2'd0, 2'd1, 2'd2};

    initial begin
        logic [3:0] nt_pred;
        logic [3:0] nt_misp;
        logic [7:0] nt_after;
        nt_pred  = NT_PRED;
        nt_misp  = NT_MISP;
        nt_after = NT_AFTER;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        i_pc = '0; i_dec_advance = 1'b0; i_ex_advance = 1'b0;
        bd.valid = 1'b0; bd.is_jump = 1'b0; bd.target = '0;
        br.valid = 1'b0; br.prediction = NOT_TAKEN; br.outcome = NOT_TAKEN; br.recovery_target = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and first prediction
        dec(32'h40, 32'h100);
        expect_val(S_PRED, 0, 32'd0);
        expect_val(S_RTGT, 0, 32'h100);
        expect_val(S_BCNT, 0, 32'd0);
        expect_val(S_MCNT, 0, 32'd0);
        expect_val(S_OVF, 0, 32'd0);
        expect_val(S_BHT, 16, 32'd1);
        expect_val(S_BHT, 0, 32'd1);
        res(1'b0, 1'b1);
        expect_val(S_OCC, 0, 32'd1);
        expect_val(S_MISP, 0, 32'd1);

        // Training 01 -> 10 -> 11
        dec(32'h40, 32'h100);
        expect_val(S_BHT, 16, 32'd2);
        expect_val(S_BCNT, 0, 32'd1);
        expect_val(S_MCNT, 0, 32'd1);
        expect_val(S_OCC, 0, 32'd0);
        expect_val(S_PRED, 0, 32'd1);
        expect_val(S_RTGT, 0, 32'h48);
        res(1'b1, 1'b1);
        expect_val(S_MISP, 0, 32'd0);
        dec(32'h40, 32'h100);
        expect_val(S_BHT, 16, 32'd3);
        expect_val(S_BCNT, 0, 32'd2);
        expect_val(S_MCNT, 0, 32'd1);
        expect_val(S_PRED, 0, 32'd1);
        expect_val(S_RTGT, 0, 32'h48);
        res(1'b1, 1'b1);
        expect_val(S_MISP, 0, 32'd0);

        // Saturation high: four more TAKEN resolutions (five in total beyond training)
        for (int i = 0; i < 4; i++) begin
            dec(32'h40, 32'h100);
            expect_val(S_PRED, 0, 32'd1);
            expect_val(S_BHT, 16, 32'd3);
            res(1'b1, 1'b1);
            expect_val(S_MISP, 0, 32'd0);
        end
        idle();
        expect_val(S_BHT, 16, 32'd3);
        expect_val(S_BCNT, 0, 32'd7);
        expect_val(S_MCNT, 0, 32'd1);

        // Saturation low: four NOT_TAKEN resolutions, 11 -> 10 -> 01 -> 00 -> 00
        for (int r = 0; r < 4; r++) begin
            dec(32'h40, 32'h100);
            expect_val(S_PRED, 0, 32'(nt_pred[r]));
            expect_val(S_RTGT, 0, nt_pred[r] ? 32'h48 : 32'h100);
            res(nt_pred[r], 1'b0);
            expect_val(S_MISP, 0, 32'(nt_misp[r]));
            idle();
            expect_val(S_BHT, 16, 32'(nt_after[2*r +: 2]));
        end
        expect_val(S_BCNT, 0, 32'd11);
        expect_val(S_MCNT, 0, 32'd3);
        expect_val(S_OCC, 0, 32'd0);

        // Jump: taken to its target, no queue push, no training
        drive(32'h80, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(S_PRED, 0, 32'd1);
        expect_val(S_RTGT, 0, 32'h200);
        idle();
        expect_val(S_OCC, 0, 32'd0);
        expect_val(S_BHT, 32, 32'd1);

        // Flush on mispredict with a same-cycle push
        dec(32'h04, 32'h104);
        expect_val(S_PRED, 0, 32'd0);
        expect_val(S_RTGT, 0, 32'h104);
        dec(32'h08, 32'h108);
        dec(32'h0C, 32'h10C);
        drive(32'h10, 1'b1, 1'b0, 32'h110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_val(S_OCC, 0, 32'd3);
        expect_val(S_MISP, 0, 32'd1);
        expect_val(S_PRED, 0, 32'd0);
        res(1'b1, 1'b1);
        expect_val(S_OCC, 0, 32'd0);
        expect_val(S_BHT, 1, 32'd2);
        expect_val(S_BHT, 2, 32'd1);
        expect_val(S_BHT, 3, 32'd1);
        expect_val(S_BHT, 4, 32'd1);
        expect_val(S_BCNT, 0, 32'd12);
        expect_val(S_MCNT, 0, 32'd4);
        expect_val(S_MISP, 0, 32'd0);
        idle();
        expect_val(S_BCNT, 0, 32'd13);
        expect_val(S_MCNT, 0, 32'd4);
        expect_val(S_BHT, 1, 32'd2);
        expect_val(S_BHT, 3, 32'd1);
        expect_val(S_OCC, 0, 32'd0);

        // Full queue and overflow
        dec(32'h14, 32'h114);
        dec(32'h18, 32'h118);
        dec(32'h1C, 32'h11C);
        dec(32'h20, 32'h120);
        dec(32'h24, 32'h124);
        expect_val(S_OCC, 0, 32'd4);
        expect_val(S_OVF, 0, 32'd0);
        expect_val(S_PRED, 0, 32'd0);
        expect_val(S_RTGT, 0, 32'h124);
        idle();
        expect_val(S_OVF, 0, 32'd1);
        expect_val(S_OCC, 0, 32'd4);
        idle();
        idle();
        expect_val(S_OVF, 0, 32'd1);
        expect_val(S_OCC, 0, 32'd4);
        drive(32'h28, 1'b1, 1'b0, 32'h128, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_val(S_MISP, 0, 32'd0);
        res(1'b1, 1'b1);
        expect_val(S_OCC, 0, 32'd4);
        expect_val(S_OVF, 0, 32'd1);
        expect_val(S_BHT, 5, 32'd0);
        expect_val(S_BCNT, 0, 32'd14);
        idle();
        expect_val(S_BHT, 6, 32'd2);
        expect_val(S_OCC, 0, 32'd3);
        expect_val(S_BCNT, 0, 32'd15);
        expect_val(S_MCNT, 0, 32'd4);
        expect_val(S_BHT, 9, 32'd1);

        // Asynchronous reset mid-operation
        @(posedge clk);
        #1 rst = 1'b1;
        expect_val(S_OCC, 0, 32'd0);
        expect_val(S_OVF, 0, 32'd0);
        expect_val(S_BCNT, 0, 32'd0);
        expect_val(S_MCNT, 0, 32'd0);
        expect_val(S_BHT, 6, 32'd1);
        expect_val(S_BHT, 16, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        dec(32'h40, 32'h100);
        expect_val(S_PRED, 0, 32'd0);
        expect_val(S_RTGT, 0, 32'h100);
        idle();

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        #1;
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s idx=%0d never compared, required=0x%0h", sel_name(e.sel), e.idx, e.val);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor_unit.md
# branch_predictor_unit

Dynamic branch predictor and the responder side of the branch handshake driven by the decode and EX glue logic. In decode it consumes `branch_decoded` (valid, is_jump, target) plus the branch PC, and returns `prediction` and `recovery_target`. In EX it consumes `branch_result` and trains a table of 2-bit saturating counters. A small in-order queue of table indices ties each resolved result back to the entry that predicted it, because `branch_result` carries no PC.

## Interface
- `INDEX_WIDTH`, default 6: BHT index width (2^6 = 64 counters), indexed by `i_pc[INDEX_WIDTH+1:2]`.
- `QUEUE_DEPTH`, default 4: depth of the in-flight branch index queue; must be a power of 2.
- `clk`  in  1  clock. Reset is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `i_pc`  in  `ADDR_WIDTH`  PC of the instruction in decode.
- `i_dec_advance`  in  1  decode instruction moves to EX this cycle.
- `i_ex_advance`  in  1  EX instruction retires from EX this cycle.
- `branch_decoded`  `branch_decoded_ifc.hazard`  –  in: valid, is_jump, target; out: prediction, recovery_target.
- `branch_result`  `branch_result_ifc.in`  –  valid, prediction, outcome, recovery_target.
- `o_mispredict`  out  1  combinational; high when `branch_result.valid & i_ex_advance & (prediction != outcome)`.
- `o_branch_count`  out  32  resolved conditional branches, saturating.
- `o_mispredict_count`  out  32  mispredicted branches, saturating.
- `o_overflow`  out  1  sticky; set when a push is dropped because the queue is full.

## Operation
- **Predict (combinational):**
  - `is_jump`: prediction = TAKEN; recovery_target = `branch_decoded.target`.
  - Conditional branch: prediction = TAKEN iff `bht[idx][1]`.
    - Predicted TAKEN: recovery_target = `i_pc + 8` (past the delay slot).
    - Predicted NOT_TAKEN: recovery_target = `target`.
  - `branch_decoded.valid = 0`: outputs are don't-care; drive NOT_TAKEN and `i_pc + 8`.
- **Push:** when `valid & ~is_jump & i_dec_advance`, enqueue idx.
- **Pop:** when `branch_result.valid & i_ex_advance`, dequeue the head idx.
  - Update `bht[head]` using `outcome`: TAKEN increments, NOT_TAKEN decrements, saturating at 0 and 3.
  - Increment `o_branch_count`. On a mispredict, also increment `o_mispredict_count`.
- **Mispredict recovery:** after the pop, clear the queue. Entries behind the head are wrong-path. A push in the same cycle is also discarded.
- **Simultaneous push and pop, no mispredict:** both take effect. Allowed even when the queue is full; occupancy is unchanged.
- **Push while full with no pop:** drop the entry and set `o_overflow`. The prediction is still returned.
- **Pop while empty:** no BHT update. Counters still increment.
- **Read during update:** a predict and a train to the same idx in the same cycle read the old counter. There is no bypass.

## Timing
- Prediction has zero-cycle latency from `i_pc` and `branch_decoded`.
- BHT, queue and statistics updates are registered at the rising edge of `clk`. An updated counter is visible to a prediction on the next cycle.
- `o_mispredict` is combinational in the EX cycle.
- On `rst` assertion, at any time and independent of `clk`:
  - every BHT entry = 2'b01 (weakly not-taken);
  - queue empty, with read and write pointers 0;
  - `o_branch_count` = 0, `o_mispredict_count` = 0, `o_overflow` = 0.
- Reset asserted mid-operation discards all in-flight entries.
- Queue pointers are `$clog2(QUEUE_DEPTH)+1` bits and wrap modulo 2·DEPTH.
  - full = MSBs differ and low bits are equal.
  - empty = pointers equal.

## Structure
- Add `bht_counter_t` (2-bit) and the constants `BHT_WEAK_NT = 2'b01` and `BHT_MAX = 2'b11` to `mips_core_pkg`, next to `branch_outcome_t`.
- Sub-module `branch_index_queue`: a parameterised synchronous FIFO with push, pop, flush, full, empty and head outputs. The BHT array and the counter logic stay in the top module.

## Test plan
- **Reset and first prediction:** release reset; present a branch at `i_pc = 0x40`, `target = 0x100`.
  - Expect NOT_TAKEN with recovery_target = `0x100`.
  - Expect both counts = 0.
- **Training:** issue and resolve branch `0x40` TAKEN twice.
  - Expect `bht[16]` = 01 → 10 → 11.
  - Expect the third prediction TAKEN with recovery_target = `0x48`.
  - Expect `o_mispredict` high on the first result only; `o_mispredict_count = 1`.
- **Saturation:** resolve the same branch TAKEN five more times.
  - Expect the counter to stay at 11.
  - Then resolve NOT_TAKEN four times; expect the counter to saturate at 00.
- **Jump:** present `is_jump = 1`, `target = 0x200`.
  - Expect TAKEN with recovery_target = `0x200`.
  - Expect no queue push: occupancy unchanged and no BHT change.
- **Flush on mispredict:** push 3 branches (idx 1, 2, 3); resolve idx 1 as a mispredict while pushing idx 4 in the same cycle.
  - Expect only `bht[1]` updated and the queue empty afterwards.
  - A subsequent result with an empty queue causes no BHT change but `o_branch_count` increments.
- **Full and overflow:** fill 4 entries, then push with no pop.
  - Expect `o_overflow = 1`, remaining set after further cycles, and occupancy = 4.
  - Then push and pop in the same cycle: expect occupancy 4 and `o_overflow` still 1.
